data_line: RTL and testbench
============================

DATA_LINE -- requirements
Module: data_line

Interface
REQ-001 Parameter AP_DIGITS, default 3: number of BCD digits in the data address pointer; the cell count is 10^AP_DIGITS.
REQ-002 Parameter DATA_WIDTH, default 8: width of each data cell.
REQ-003 Port Clk, input, 1: clock.
REQ-004 Port Rst_n, input, 1: reset, synchronous, active-low.
REQ-005 Port Request, input, 1: single-cycle pulse that requests execution of Insn.
REQ-006 Port Insn, input, 4: instruction code from the IP line, valid in the cycle Request is high.
REQ-007 Port Ready, output, 1: single-cycle pulse marking completion of the accepted instruction.
REQ-008 Port dataIsZeroed, output, 1: high when the cached current cell equals 0.
REQ-009 Port ApAddress, output, 4*AP_DIGITS: current data pointer, BCD, digit 0 in the LSBs.
REQ-010 Port Data, output, DATA_WIDTH: cached value of the cell at ApAddress.
REQ-011 Port InitDone, output, 1: high once the post-reset RAM clear sweep has finished.

Function
REQ-012 Insn encodings: 0010 = DATA_INC, 0011 = DATA_DEC, 0100 = AP_INC, 0101 = AP_DEC; every other code is NOP for this block (loop and halt codes included).
REQ-013 The FSM states are CLEAR, IDLE, EXEC, SHIFT, FETCH, LOAD and DONE.
REQ-014 CLEAR: write 0 to cells 0..10^AP_DIGITS-1, one cell per cycle, then go to IDLE and set InitDone=1.
REQ-015 Request is sampled only in IDLE; Insn is latched on the same edge; Request in any other state is ignored with no side effect.
REQ-016 DATA_INC/DEC path is IDLE→EXEC→DONE→IDLE: in EXEC, Data <= Data±1 mod 2^DATA_WIDTH and the new value is written to RAM[Ap]; Ready is high in DONE, 2 cycles after the Request edge.
REQ-017 AP_INC/DEC path is IDLE→SHIFT→FETCH→LOAD→DONE→IDLE: SHIFT updates Ap by ±1 in BCD with digit carry/borrow; FETCH issues a RAM read of the new Ap; LOAD sets Data <= RAM output; Ready is high 4 cycles after the Request edge.
REQ-018 Ap wraps from 999 to 000 on AP_INC and from 000 to 999 on AP_DEC; no BCD digit ever holds a value above 9.
REQ-019 Data wraps from 255 to 0 on DATA_INC and from 0 to 255 on DATA_DEC.
REQ-020 NOP path is IDLE→DONE→IDLE; Ready is high 1 cycle after the Request edge, and Ap and Data are unchanged.
REQ-021 Ready is high for exactly one cycle per accepted Request and is never high outside DONE.
REQ-022 dataIsZeroed is combinational from the Data register and is stable whenever Ready is high.
REQ-023 RAM is single-port with synchronous read (1-cycle latency) and synchronous write; a write and a read never occur in the same cycle.

Reset
REQ-024 While Rst_n=0: state=CLEAR with sweep index 0, Ap=0, Data=0, Ready=0, InitDone=0, latched Insn=NOP.
REQ-025 Reset asserted mid-operation (any state, CLEAR included) aborts the operation and restarts the full clear sweep from cell 0.
REQ-026 Request is ignored until InitDone=1.

Structure
REQ-027 Package dpc_pkg shall hold the Insn encoding constants, the FSM state enum and the BCD digit typedef.
REQ-028 RAM shall be the sub-module data_ram (parameters ADDR_DIGITS and DATA_WIDTH; ports Clk, Address, WrEn, WrData, RdData).
REQ-029 BCD ±1 shall be a function in dpc_pkg, reused for Ap.

Verification
REQ-030 Reset, then wait: InitDone rises exactly 1000 cycles after Rst_n deasserts; Ap=000, Data=0, dataIsZeroed=1.
REQ-031 DATA_INC ×3 then DATA_DEC ×1: Data=2, dataIsZeroed=0, and each Ready arrives 2 cycles after its Request.
REQ-032 DATA_INC ×5, AP_INC, DATA_INC, AP_DEC: Ap=000 and Data=5 on the final Ready; cell 001 holds 1.
REQ-033 AP_DEC from 000: Ap=999, Data=0, Ready after 4 cycles; then AP_INC gives Ap=000; 9 × AP_INC from 000 gives Ap=009, and one more gives 010.
REQ-034 DATA_DEC from 0: Data=255; then DATA_INC gives 0 with dataIsZeroed=1; Insn=0001 gives Ready after 1 cycle with no state change.
REQ-035 Request pulsed during EXEC, and Rst_n pulsed during FETCH: the extra Request produces no second Ready, and the reset restarts the clear sweep with all cells reading 0 afterwards.

Source files
------------

// File: rtl/dpc_pkg.sv
// Shared definitions for the data-pointer line: instruction codes, FSM states
// and the single-digit BCD step used for pointer and sweep arithmetic.
package dpc_pkg;

  localparam logic [3:0] INSN_NOP      = 4'h0;
  localparam logic [3:0] INSN_DATA_INC = 4'h2;
  localparam logic [3:0] INSN_DATA_DEC = 4'h3;
  localparam logic [3:0] INSN_AP_INC   = 4'h4;
  localparam logic [3:0] INSN_AP_DEC   = 4'h5;

  typedef enum logic [2:0] {CLEAR, IDLE, EXEC, SHIFT, FETCH, LOAD, DONE} state_t;

  typedef logic [3:0] bcd_digit_t;

  typedef struct packed {
    logic       carry;
    bcd_digit_t digit;
  } bcd_step_t;

  // Step one digit by +/-cin; carry out means the digit wrapped (9->0 or 0->9).
  function automatic bcd_step_t bcd_digit_step(input bcd_digit_t d, input logic dec,
                                               input logic cin);
    bcd_step_t r;
    r.carry = 1'b0;
    r.digit = d;
    if (cin) begin
      if (dec) begin
        if (d == 4'd0) begin
          r.carry = 1'b1;
          r.digit = 4'd9;
        end else begin
          r.digit = d - 4'd1;
        end
      end else begin
        if (d >= 4'd9) begin
          r.carry = 1'b1;
          r.digit = 4'd0;
        end else begin
          r.digit = d + 4'd1;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/data_ram.sv
// Single-port data cell store addressed in BCD; synchronous write, and a
// synchronous read on every cycle that does not write.
module data_ram #(
  parameter int ADDR_DIGITS = 3,
  parameter int DATA_WIDTH  = 8
) (
  input  logic                     Clk,
  input  logic [4*ADDR_DIGITS-1:0] Address,
  input  logic                     WrEn,
  input  logic [DATA_WIDTH-1:0]    WrData,
  output logic [DATA_WIDTH-1:0]    RdData
);

  localparam int DEPTH = 10 ** ADDR_DIGITS;
  localparam int IW    = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [IW-1:0]         idx;

  // BCD -> linear cell index, most significant digit first.
  always_comb begin
    int acc;
    acc = 0;
    for (int i = ADDR_DIGITS - 1; i >= 0; i--)
      acc = acc * 10 + int'(Address[4*i +: 4]);
    idx = IW'(acc);
  end

  always_ff @(posedge Clk) begin
    if (WrEn) mem[idx] <= WrData;
    else      RdData   <= mem[idx];
  end

endmodule

// File: rtl/data_line.sv
// Data cell line: BCD data pointer plus a cached copy of the cell it points at,
// with a post-reset clear sweep over the whole cell store.
module data_line
  import dpc_pkg::*;
#(
  parameter int AP_DIGITS  = 3,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    Request,
  input  logic [3:0]              Insn,
  output logic                    Ready,
  output logic                    dataIsZeroed,
  output logic [4*AP_DIGITS-1:0]  ApAddress,
  output logic [DATA_WIDTH-1:0]   Data,
  output logic                    InitDone
);

  localparam int AW = 4 * AP_DIGITS;

  state_t                state_q, state_d;
  logic [3:0]            insn_q;
  logic [AW-1:0]         ap_q, ap_step, clr_q, clr_step, ram_addr;
  logic                  clr_last, op_dec, wr_en, init_q;
  logic [DATA_WIDTH-1:0] data_q, data_nxt, rd_data, wr_data;

  assign op_dec   = (insn_q == INSN_DATA_DEC) || (insn_q == INSN_AP_DEC);
  assign data_nxt = op_dec ? data_q - DATA_WIDTH'(1) : data_q + DATA_WIDTH'(1);

  // Ripple the +/-1 through the digits; sweep reaching all-nines shows up as carry out.
  always_comb begin
    logic      ca, cc;
    bcd_step_t sa, sc;
    ca       = 1'b1;
    cc       = 1'b1;
    sa       = '0;
    sc       = '0;
    ap_step  = ap_q;
    clr_step = clr_q;
    for (int i = 0; i < AP_DIGITS; i++) begin
      sa = bcd_digit_step(ap_q[4*i +: 4], op_dec, ca);
      ap_step[4*i +: 4] = sa.digit;
      ca = sa.carry;
      sc = bcd_digit_step(clr_q[4*i +: 4], 1'b0, cc);
      clr_step[4*i +: 4] = sc.digit;
      cc = sc.carry;
    end
    clr_last = cc;
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) state_q <= CLEAR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    Ready   = 1'b0;
    wr_en   = 1'b0;
    case (state_q)
      CLEAR: begin
        wr_en = 1'b1;
        if (clr_last) state_d = IDLE;
      end
      IDLE: begin
        if (Request) begin
          case (Insn)
            INSN_DATA_INC, INSN_DATA_DEC: state_d = EXEC;
            INSN_AP_INC, INSN_AP_DEC:     state_d = SHIFT;
            default:                      state_d = DONE;
          endcase
        end
      end
      EXEC: begin
        wr_en   = 1'b1;
        state_d = DONE;
      end
      SHIFT: state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD:  state_d = DONE;
      DONE: begin
        Ready   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      clr_q  <= '0;
      ap_q   <= '0;
      data_q <= '0;
      insn_q <= INSN_NOP;
      init_q <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          clr_q <= clr_step;
          if (clr_last) init_q <= 1'b1;
        end
        IDLE:  if (Request) insn_q <= Insn;
        EXEC:  data_q <= data_nxt;
        SHIFT: ap_q   <= ap_step;
        LOAD:  data_q <= rd_data;
        default: ;
      endcase
    end
  end

  // Gating with Rst_n keeps an aborted EXEC from writing in the reset cycle.
  assign ram_addr = (state_q == CLEAR) ? clr_q : ap_q;
  assign wr_data  = (state_q == CLEAR) ? '0 : data_nxt;

  data_ram #(
    .ADDR_DIGITS(AP_DIGITS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .Clk    (Clk),
    .Address(ram_addr),
    .WrEn   (wr_en & Rst_n),
    .WrData (wr_data),
    .RdData (rd_data)
  );

  assign ApAddress    = ap_q;
  assign Data         = data_q;
  assign dataIsZeroed = (data_q == '0);
  assign InitDone     = init_q;

endmodule

// File: tb/tb_data_line.sv
// Directed bench for data_line: clear sweep timing, data and pointer arithmetic,
// wrap cases, NOP latency, ignored requests and mid-operation reset.
module tb_data_line;
  import dpc_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Request = 1'b0;
  logic [3:0]  Insn = 4'h0;
  logic        Ready, dataIsZeroed, InitDone;
  logic [11:0] ApAddress;
  logic [7:0]  Data;

  int n_cmp = 0;
  int n_err = 0;

  data_line #(.AP_DIGITS(3), .DATA_WIDTH(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Request(Request), .Insn(Insn), .Ready(Ready),
    .dataIsZeroed(dataIsZeroed), .ApAddress(ApAddress), .Data(Data), .InitDone(InitDone)
  );

  always #5 Clk = ~Clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, want finish before 1ms");
    $fatal(1);
  end

  // Starts and ends #1 after a posedge with the DUT in IDLE.
  task automatic issue(input logic [3:0] code, output int lat, output logic one_shot);
    Request = 1'b1;
    Insn    = code;
    @(posedge Clk); #1;
    Request = 1'b0;
    Insn    = 4'h0;
    lat = 1;
    while (!Ready && lat < 20) begin
      @(posedge Clk); #1;
      lat++;
    end
    if (!Ready) lat = -1;
    @(posedge Clk); #1;
    one_shot = !Ready;
  endtask

  task automatic test_reset();
    int cnt;
    Rst_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    n_cmp++; if (Ready !== 1'b0)    begin n_err++; $display("FAIL rst_ready: got %b want 0", Ready); end
    n_cmp++; if (InitDone !== 1'b0) begin n_err++; $display("FAIL rst_initdone: got %b want 0", InitDone); end
    n_cmp++; if (ApAddress !== 12'h000) begin n_err++; $display("FAIL rst_ap: got %h want 000", ApAddress); end
    n_cmp++; if (Data !== 8'd0)     begin n_err++; $display("FAIL rst_data: got %0d want 0", Data); end
    Rst_n = 1'b1;
    cnt = 0;
    while (!InitDone && cnt < 1100) begin
      if (cnt == 10) begin Request = 1'b1; Insn = INSN_DATA_INC; end
      else Request = 1'b0;
      @(posedge Clk); #1;
      cnt++;
    end
    Request = 1'b0;
    n_cmp++; if (cnt !== 1000) begin n_err++; $display("FAIL init_cycles: got %0d want 1000", cnt); end
    repeat (3) @(posedge Clk);
    #1;
    n_cmp++; if (ApAddress !== 12'h000) begin n_err++; $display("FAIL init_ap: got %h want 000", ApAddress); end
    n_cmp++; if (Data !== 8'd0)         begin n_err++; $display("FAIL init_data: got %0d want 0", Data); end
    n_cmp++; if (dataIsZeroed !== 1'b1) begin n_err++; $display("FAIL init_zeroed: got %b want 1", dataIsZeroed); end
    n_cmp++; if (Ready !== 1'b0)        begin n_err++; $display("FAIL init_ready: got %b want 0", Ready); end
  endtask

  task automatic test_data_incdec();
    logic [3:0] codes [4] = '{INSN_DATA_INC, INSN_DATA_INC, INSN_DATA_INC, INSN_DATA_DEC};
    logic [7:0] exp_d [4] = '{8'd1, 8'd2, 8'd3, 8'd2};
    int lat; logic os;
    for (int i = 0; i < 4; i++) begin
      issue(codes[i], lat, os);
      n_cmp++; if (lat !== 2)      begin n_err++; $display("FAIL data_lat[%0d]: got %0d want 2", i, lat); end
      n_cmp++; if (os !== 1'b1)    begin n_err++; $display("FAIL data_oneshot[%0d]: got %b want 1", i, os); end
      n_cmp++; if (Data !== exp_d[i]) begin n_err++; $display("FAIL data_val[%0d]: got %0d want %0d", i, Data, exp_d[i]); end
      n_cmp++; if (dataIsZeroed !== (exp_d[i] == 8'd0)) begin n_err++; $display("FAIL data_zeroed[%0d]: got %b want %b", i, dataIsZeroed, exp_d[i] == 8'd0); end
      n_cmp++; if (ApAddress !== 12'h000) begin n_err++; $display("FAIL data_ap[%0d]: got %h want 000", i, ApAddress); end
    end
  endtask

  task automatic test_ap_move();
    logic [3:0]  codes [12] = '{INSN_DATA_DEC, INSN_DATA_DEC, INSN_DATA_INC, INSN_DATA_INC,
                                INSN_DATA_INC, INSN_DATA_INC, INSN_DATA_INC, INSN_AP_INC,
                                INSN_DATA_INC, INSN_AP_DEC, INSN_AP_INC, INSN_AP_DEC};
    int          exp_l [12] = '{2, 2, 2, 2, 2, 2, 2, 4, 2, 4, 4, 4};
    logic [11:0] exp_a [12] = '{12'h000, 12'h000, 12'h000, 12'h000, 12'h000, 12'h000,
                                12'h000, 12'h001, 12'h001, 12'h000, 12'h001, 12'h000};
    logic [7:0]  exp_d [12] = '{8'd1, 8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd0, 8'd1, 8'd5, 8'd1, 8'd5};
    int lat; logic os;
    for (int i = 0; i < 12; i++) begin
      issue(codes[i], lat, os);
      n_cmp++; if (lat !== exp_l[i]) begin n_err++; $display("FAIL move_lat[%0d]: got %0d want %0d", i, lat, exp_l[i]); end
      n_cmp++; if (os !== 1'b1)      begin n_err++; $display("FAIL move_oneshot[%0d]: got %b want 1", i, os); end
      n_cmp++; if (ApAddress !== exp_a[i]) begin n_err++; $display("FAIL move_ap[%0d]: got %h want %h", i, ApAddress, exp_a[i]); end
      n_cmp++; if (Data !== exp_d[i]) begin n_err++; $display("FAIL move_data[%0d]: got %0d want %0d", i, Data, exp_d[i]); end
    end
  endtask

  task automatic test_ap_wrap();
    logic [11:0] exp_a [12] = '{12'h999, 12'h000, 12'h001, 12'h002, 12'h003, 12'h004,
                                12'h005, 12'h006, 12'h007, 12'h008, 12'h009, 12'h010};
    logic [7:0]  exp_d [12] = '{8'd0, 8'd5, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    int lat; logic os;
    for (int i = 0; i < 12; i++) begin
      issue((i == 0) ? INSN_AP_DEC : INSN_AP_INC, lat, os);
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL wrap_lat[%0d]: got %0d want 4", i, lat); end
      n_cmp++; if (ApAddress !== exp_a[i]) begin n_err++; $display("FAIL wrap_ap[%0d]: got %h want %h", i, ApAddress, exp_a[i]); end
      n_cmp++; if (Data !== exp_d[i]) begin n_err++; $display("FAIL wrap_data[%0d]: got %0d want %0d", i, Data, exp_d[i]); end
    end
  endtask

  task automatic test_data_wrap();
    logic [3:0] codes [5] = '{INSN_DATA_DEC, INSN_DATA_INC, 4'h1, 4'hF, 4'h6};
    int         exp_l [5] = '{2, 2, 1, 1, 1};
    logic [7:0] exp_d [5] = '{8'd255, 8'd0, 8'd0, 8'd0, 8'd0};
    int lat; logic os;
    for (int i = 0; i < 5; i++) begin
      issue(codes[i], lat, os);
      n_cmp++; if (lat !== exp_l[i]) begin n_err++; $display("FAIL dwrap_lat[%0d]: got %0d want %0d", i, lat, exp_l[i]); end
      n_cmp++; if (os !== 1'b1)      begin n_err++; $display("FAIL dwrap_oneshot[%0d]: got %b want 1", i, os); end
      n_cmp++; if (Data !== exp_d[i]) begin n_err++; $display("FAIL dwrap_data[%0d]: got %0d want %0d", i, Data, exp_d[i]); end
      n_cmp++; if (dataIsZeroed !== (exp_d[i] == 8'd0)) begin n_err++; $display("FAIL dwrap_zeroed[%0d]: got %b want %b", i, dataIsZeroed, exp_d[i] == 8'd0); end
      n_cmp++; if (ApAddress !== 12'h010) begin n_err++; $display("FAIL dwrap_ap[%0d]: got %h want 010", i, ApAddress); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  codes [3] = '{INSN_AP_INC, INSN_AP_DEC, INSN_AP_DEC};
    logic [11:0] exp_a [3] = '{12'h001, 12'h000, 12'h999};
    int readies, cnt, lat; logic os;
    // Second Request held across the EXEC edge must be ignored.
    Request = 1'b1; Insn = INSN_DATA_INC;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    Request = 1'b0; Insn = 4'h0;
    n_cmp++; if (Ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b want 1", Ready); end
    readies = 0;
    repeat (8) begin @(posedge Clk); #1; if (Ready) readies++; end
    n_cmp++; if (readies !== 0) begin n_err++; $display("FAIL b2b_extra_ready: got %0d want 0", readies); end
    n_cmp++; if (Data !== 8'd1) begin n_err++; $display("FAIL b2b_data: got %0d want 1", Data); end
    // Reset lands while the AP_INC is in FETCH.
    Request = 1'b1; Insn = INSN_AP_INC;
    @(posedge Clk); #1;
    Request = 1'b0; Insn = 4'h0;
    @(posedge Clk); #1;
    Rst_n = 1'b0;
    @(posedge Clk); #1;
    n_cmp++; if (Ready !== 1'b0)    begin n_err++; $display("FAIL abort_ready: got %b want 0", Ready); end
    n_cmp++; if (InitDone !== 1'b0) begin n_err++; $display("FAIL abort_initdone: got %b want 0", InitDone); end
    n_cmp++; if (ApAddress !== 12'h000) begin n_err++; $display("FAIL abort_ap: got %h want 000", ApAddress); end
    Rst_n = 1'b1;
    cnt = 0; readies = 0;
    while (!InitDone && cnt < 1100) begin
      @(posedge Clk); #1;
      cnt++;
      if (Ready) readies++;
    end
    n_cmp++; if (cnt !== 1000)  begin n_err++; $display("FAIL abort_init_cycles: got %0d want 1000", cnt); end
    n_cmp++; if (readies !== 0) begin n_err++; $display("FAIL abort_sweep_ready: got %0d want 0", readies); end
    for (int i = 0; i < 3; i++) begin
      issue(codes[i], lat, os);
      n_cmp++; if (lat !== 4) begin n_err++; $display("FAIL clr_lat[%0d]: got %0d want 4", i, lat); end
      n_cmp++; if (ApAddress !== exp_a[i]) begin n_err++; $display("FAIL clr_ap[%0d]: got %h want %h", i, ApAddress, exp_a[i]); end
      n_cmp++; if (Data !== 8'd0) begin n_err++; $display("FAIL clr_data[%0d]: got %0d want 0", i, Data); end
    end
  endtask

  initial begin
    test_reset();
    test_data_incdec();
    test_ap_move();
    test_ap_wrap();
    test_data_wrap();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
